tap_ram_writer: RTL
===================

TAP_RAM_WRITER -- requirements
Module: tap_ram_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of buffered {addr,data} entries (power of two, 2..16).
REQ-002 SHALL have parameter PTR_ADDR, default 16'h009C, meaning the BASIC end-of-program pointer address (low byte; high byte at PTR_ADDR+1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port tape_wr, input, 1 bit: upstream tape write qualifier (level; may stay high).
REQ-006 SHALL have port tape_addr, input, 16 bits: upstream target RAM address.
REQ-007 SHALL have port tape_dout, input, 8 bits: upstream data byte.
REQ-008 SHALL have port tape_complete, input, 1 bit: upstream level, high once the last byte has been presented.
REQ-009 SHALL have port autostart, input, 1 bit: upstream autorun flag, sampled on entry to DONE.
REQ-010 SHALL have port ram_slot, input, 1 bit: high in cycles where the CPU is not accessing RAM.
REQ-011 SHALL have port ram_we, output, 1 bit: RAM write enable.
REQ-012 SHALL have port ram_addr, output, 16 bits: RAM write address.
REQ-013 SHALL have port ram_dout, output, 8 bits: RAM write data.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE and DONE.
REQ-015 SHALL have port done, output, 1 bit: high while in DONE.
REQ-016 SHALL have port run_req, output, 1 bit: single-cycle pulse requesting an auto-RUN.
REQ-017 SHALL have port overflow, output, 1 bit: sticky; set when a capture is dropped because the FIFO is full.

Function
REQ-018 Capture SHALL occur in a cycle where tape_wr=1 and either first_flag=1 or tape_addr != last_addr; on capture, last_addr<=tape_addr and first_flag<=0.
REQ-019 Captures SHALL push {tape_addr,tape_dout} into the FIFO only in states IDLE, STREAM or DRAIN; captures in PATCH_LO, PATCH_HI or DONE SHALL be ignored, and last_addr SHALL NOT update in those states.
REQ-020 A capture while the FIFO is full SHALL be dropped and SHALL set overflow; last_addr SHALL still update.
REQ-021 ram_we SHALL be combinational: ram_slot AND (FIFO non-empty in STREAM/DRAIN, or state PATCH_LO/PATCH_HI); ram_addr/ram_dout SHALL be driven from registered state only.
REQ-022 In STREAM/DRAIN, ram_addr/ram_dout SHALL equal the FIFO head; each cycle with ram_we=1 SHALL pop one entry at the clock edge.
REQ-023 A push and a pop in the same cycle SHALL both take effect, with count unchanged; a capture into an empty FIFO SHALL NOT be written in the same cycle (minimum latency: 1 cycle from capture to ram_we).
REQ-024 States SHALL be IDLE, STREAM, DRAIN, PATCH_LO, PATCH_HI, DONE.
REQ-025 IDLE->STREAM SHALL occur on the first capture.
REQ-026 STREAM->DRAIN SHALL occur when tape_complete=1.
REQ-027 DRAIN->PATCH_LO SHALL occur when the FIFO is empty with no push in that cycle.
REQ-028 PATCH_LO SHALL drive ram_addr=PTR_ADDR, ram_dout=end_ptr[7:0]; it SHALL advance to PATCH_HI on the cycle ram_we=1.
REQ-029 PATCH_HI SHALL drive ram_addr=PTR_ADDR+1, ram_dout=end_ptr[15:8]; it SHALL advance to DONE on the cycle ram_we=1.
REQ-030 end_ptr SHALL be last_addr+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-031 On entry to DONE, run_req SHALL pulse high for exactly one cycle if autostart=1.
REQ-032 DONE->IDLE SHALL occur when tape_complete=0; this SHALL also set first_flag=1.
REQ-033 tape_complete=1 while in IDLE SHALL keep the state in IDLE; there SHALL be no patch without data.
REQ-034 PATCH writes with ram_slot=0 SHALL stall; no FIFO or patch write SHALL be lost or repeated.

Reset
REQ-035 While reset=1, the block SHALL asynchronously enter IDLE with FIFO empty, first_flag=1, last_addr=0, and overflow=0.
REQ-036 While reset=1, ram_we, busy, done and run_req SHALL be 0, and ram_addr and ram_dout SHALL be 0.
REQ-037 Reset mid-operation SHALL discard buffered entries and any pending patch.

Verification
REQ-038 Scenario: ram_slot=1, bytes 11,22,33 at 0x0501..0x0503, then tape_complete -> RAM writes 0x0501=11, 0x0502=22, 0x0503=33, then 0x009C=04 and 0x009D=05; done=1.
REQ-039 Scenario: ram_slot=0 for 10 cycles while 6 distinct addresses are captured (FIFO_DEPTH=4) -> the first 4 entries are written once ram_slot=1, and overflow=1.
REQ-040 Scenario: tape_wr held high with tape_addr constant at 0x0600 for 20 cycles -> exactly one RAM write to 0x0600.
REQ-041 Scenario: last byte at 0xFFFF -> patch writes 0x009C=00 and 0x009D=00.
REQ-042 Scenario: autostart=1 at DONE entry -> run_req high exactly 1 cycle; with autostart=0, run_req stays 0.
REQ-043 Scenario: reset asserted in DRAIN with 2 entries buffered -> no further ram_we, all outputs 0; a new load after reset patches correctly.

Source files
------------

// File: rtl/tap_ram_writer.sv
// Tape-to-RAM writer: buffers tape bytes in a small FIFO and writes them into idle RAM slots.
// After the last byte it patches the BASIC end-of-program pointer and can request an auto-RUN.
//
// state    | meaning
// IDLE     | waiting for the first tape byte of a load
// STREAM   | tape running; buffered bytes written as RAM slots allow
// DRAIN    | tape finished; flushing the remaining FIFO entries
// PATCH_LO | writing end pointer low byte to PTR_ADDR
// PATCH_HI | writing end pointer high byte to PTR_ADDR+1
// DONE     | load finished; waits for tape_complete to drop
module tap_ram_writer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] PTR_ADDR   = 16'h009C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tape_wr,
  input  logic [15:0] tape_addr,
  input  logic [7:0]  tape_dout,
  input  logic        tape_complete,
  input  logic        autostart,
  input  logic        ram_slot,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        busy,
  output logic        done,
  output logic        run_req,
  output logic        overflow
);

  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   C_DEPTH = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, STREAM, DRAIN, PATCH_LO, PATCH_HI, DONE
  } state_t;

  state_t        r_state;
  logic          r_first;
  logic [15:0]   r_last_addr;
  logic          r_overflow;
  logic          r_run_req;

  logic [15:0]   r_fifo_addr [FIFO_DEPTH];
  logic [7:0]    r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  logic          w_capture;
  logic          w_cap_state;
  logic          w_cap_ok;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_stream_st;
  logic          w_patch_st;
  logic [15:0]   w_end_ptr;

  assign w_capture   = tape_wr && (r_first || (tape_addr != r_last_addr));
  assign w_cap_state = (r_state == IDLE) || (r_state == STREAM) || (r_state == DRAIN);
  assign w_cap_ok    = w_capture && w_cap_state;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == C_DEPTH);
  assign w_push      = w_cap_ok && !w_full;
  assign w_stream_st = (r_state == STREAM) || (r_state == DRAIN);
  assign w_patch_st  = (r_state == PATCH_LO) || (r_state == PATCH_HI);
  assign w_end_ptr   = r_last_addr + 16'd1;

  // Only the slot qualifier is combinational; address and data come from registers.
  assign ram_we = ram_slot && ((w_stream_st && !w_empty) || w_patch_st);
  assign w_pop  = ram_we && w_stream_st;

  always_comb begin
    ram_addr = '0;
    ram_dout = '0;
    case (r_state)
      STREAM, DRAIN: begin
        if (!w_empty) begin
          ram_addr = r_fifo_addr[r_rd_ptr];
          ram_dout = r_fifo_data[r_rd_ptr];
        end
      end
      PATCH_LO: begin
        ram_addr = PTR_ADDR;
        ram_dout = w_end_ptr[7:0];
      end
      PATCH_HI: begin
        ram_addr = PTR_ADDR + 16'd1;
        ram_dout = w_end_ptr[15:8];
      end
      default: begin
        ram_addr = '0;
        ram_dout = '0;
      end
    endcase
  end

  assign busy     = (r_state != IDLE) && (r_state != DONE);
  assign done     = (r_state == DONE);
  assign run_req  = r_run_req;
  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= tape_addr;
      r_fifo_data[r_wr_ptr] <= tape_dout;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_first     <= 1'b1;
      r_last_addr <= '0;
      r_overflow  <= 1'b0;
      r_run_req   <= 1'b0;
    end else begin
      r_run_req <= 1'b0;
      // A dropped capture still advances last_addr so the same address is not retried.
      if (w_cap_ok) begin
        r_last_addr <= tape_addr;
        r_first     <= 1'b0;
        if (w_full) r_overflow <= 1'b1;
      end
      case (r_state)
        IDLE:     if (w_cap_ok) r_state <= STREAM;
        STREAM:   if (tape_complete) r_state <= DRAIN;
        DRAIN:    if (w_empty && !w_push) r_state <= PATCH_LO;
        PATCH_LO: if (ram_slot) r_state <= PATCH_HI;
        PATCH_HI: begin
          if (ram_slot) begin
            r_state   <= DONE;
            r_run_req <= autostart;
          end
        end
        DONE: begin
          if (!tape_complete) begin
            r_state <= IDLE;
            r_first <= 1'b1;
          end
        end
        default:  r_state <= IDLE;
      endcase
    end
  end

endmodule
